// File: rtl/uart_tx.sv
// UART transmit serializer: start, 8 data bits LSB first, optional parity (UART_TX_PARITY_EN), one stop bit.
// Latency: start bit on tx_o the cycle after acceptance; busy_o/tc_o/tx_o are registered.
// Backpressure: requests are sampled only in IDLE; a level held while busy is not re-sampled.
module uart_tx (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        send_start_i,
  input  logic [7:0]  send_data_i,
  input  logic [5:0]  uart_cr_i,
  input  logic [15:0] uart_brr_i,
  output logic        tx_o,
  output logic        busy_o,
  output logic        tc_o
);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] brr_q, brr_d;
  logic [7:0]  shift_q, shift_d;
  logic [2:0]  idx_q, idx_d;
  logic        busy_q, busy_d;
  logic        tc_q, tc_d;
  logic        tx_q, tx_d;
  logic        ue;
  logic        bit_end;

`ifdef UART_TX_PARITY_EN
  logic        pce_q, pce_d;
  logic        par_q, par_d;
  logic        unused_cr;
  assign unused_cr = ^uart_cr_i[3:1];
`else
  logic        unused_cr;
  assign unused_cr = ^uart_cr_i[5:1];
`endif

  assign ue      = uart_cr_i[0];
  assign bit_end = (cnt_q == brr_q);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      brr_q   <= '0;
      shift_q <= '0;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      tc_q    <= 1'b0;
      tx_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
      pce_q   <= 1'b0;
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      brr_q   <= brr_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      tc_q    <= tc_d;
      tx_q    <= tx_d;
`ifdef UART_TX_PARITY_EN
      pce_q   <= pce_d;
      par_q   <= par_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 16'd1;
    brr_d   = brr_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    tc_d    = 1'b0;
`ifdef UART_TX_PARITY_EN
    pce_d   = pce_q;
    par_d   = par_q;
`endif

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (ue && send_start_i) begin
          state_d = START;
          shift_d = send_data_i;
          brr_d   = uart_brr_i;
          idx_d   = '0;
`ifdef UART_TX_PARITY_EN
          pce_d   = uart_cr_i[4];
          par_d   = (^send_data_i) ^ uart_cr_i[5];
`endif
        end
      end
      START: begin
        if (bit_end) begin
          cnt_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_d   = '0;
          shift_d = {1'b0, shift_q[7:1]};
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = pce_q ? PARITY : STOP;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          cnt_d   = '0;
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        if (bit_end) begin
          cnt_d   = '0;
          state_d = IDLE;
          tc_d    = 1'b1;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase

    // Clearing UE mid-frame drops the frame silently; it overrides any bit-end transition.
    if ((state_q != IDLE) && !ue) begin
      state_d = IDLE;
      cnt_d   = '0;
      idx_d   = '0;
      tc_d    = 1'b0;
    end

    busy_d = (state_d != IDLE);
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_d = par_d;
`endif
      default: tx_d = 1'b1;
    endcase
  end

  assign tx_o   = tx_q;
  assign busy_o = busy_q;
  assign tc_o   = tc_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: frame shape, parity, disable, abort, back-to-back, BRR latch, reset.
module tb_uart_tx;
  logic        clk = 1'b0;
  logic        rst;
  logic        send_start;
  logic [7:0]  send_data;
  logic [5:0]  cr;
  logic [15:0] brr;
  logic        tx;
  logic        busy;
  logic        tc;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_tx dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .send_start_i (send_start),
    .send_data_i  (send_data),
    .uart_cr_i    (cr),
    .uart_brr_i   (brr),
    .tx_o         (tx),
    .busy_o       (busy),
    .tc_o         (tc)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, " tx"}, {15'd0, tx}, 16'd1);
    check({tag, " busy"}, {15'd0, busy}, 16'd0);
    check({tag, " tc"}, {15'd0, tc}, 16'd0);
  endtask

  // Issues a request in the current cycle, checks every bit cycle, and returns in the tc_o cycle.
  task automatic send_frame(input string tag, input logic [7:0] d, input logic [5:0] c,
                            input logic [15:0] b, input logic [15:0] b_after,
                            input logic [5:0] c_after, input int nbits,
                            input logic [10:0] bits);
    int per;
    int len;
    logic exp_bit;
    per = int'(b) + 1;
    len = nbits * per;
    send_data  = d;
    cr         = c;
    brr        = b;
    send_start = 1'b1;
    tick();
    send_start = 1'b0;
    brr        = b_after;
    cr         = c_after;
    for (int i = 0; i < len; i++) begin
      exp_bit = bits[i / per];
      check({tag, " tx"}, {15'd0, tx}, {15'd0, exp_bit});
      check({tag, " busy"}, {15'd0, busy}, 16'd1);
      check({tag, " tc_early"}, {15'd0, tc}, 16'd0);
      tick();
    end
    check({tag, " tc"}, {15'd0, tc}, 16'd1);
    check({tag, " busy_end"}, {15'd0, busy}, 16'd0);
    check({tag, " tx_end"}, {15'd0, tx}, 16'd1);
  endtask

  initial begin
    rst        = 1'b1;
    send_start = 1'b0;
    send_data  = 8'h00;
    cr         = 6'h00;
    brr        = 16'd0;
    tick();
    tick();
    check_idle("reset");
    rst = 1'b0;
    tick();
    check_idle("post_reset");

    // 0xA5 frame: start 0, data 1,0,1,0,0,1,0,1, stop 1
    send_frame("basic", 8'hA5, 6'h01, 16'd3, 16'd3, 6'h01, 10, 11'h34A);
    tick();
    check_idle("basic_after");

    cr         = 6'h00;
    send_data  = 8'hA5;
    send_start = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick();
      check_idle("disabled");
    end
    send_start = 1'b0;

    // Abort during data bit 2 (frame bit 3, cycles N+13..N+16)
    cr         = 6'h01;
    brr        = 16'd3;
    send_data  = 8'hA5;
    send_start = 1'b1;
    tick();
    send_start = 1'b0;
    for (int i = 0; i < 13; i++) tick();
    check("abort_pre tx", {15'd0, tx}, 16'd1);
    check("abort_pre busy", {15'd0, busy}, 16'd1);
    cr = 6'h00;
    tick();
    check_idle("abort");
    for (int i = 0; i < 45; i++) begin
      tick();
      check("abort_no_tc", {15'd0, tc}, 16'd0);
    end
    cr = 6'h01;
    tick();

`ifdef UART_TX_PARITY_EN
    send_frame("par_even", 8'hA5, 6'h11, 16'd1, 16'd1, 6'h11, 11, 11'h54A);
    tick();
    check_idle("par_even_after");
    // PS/PCE changed after acceptance must not affect the frame
    send_frame("par_odd", 8'hA5, 6'h31, 16'd1, 16'd1, 6'h01, 11, 11'h74A);
    tick();
    check_idle("par_odd_after");
`else
    send_frame("nopar", 8'hA5, 6'h31, 16'd1, 16'd1, 6'h31, 10, 11'h34A);
    tick();
    check_idle("nopar_after");
`endif

    // Second request issued in the tc_o cycle of the first
    send_frame("b2b0", 8'h00, 6'h01, 16'd1, 16'd1, 6'h01, 10, 11'h200);
    send_frame("b2b1", 8'hFF, 6'h01, 16'd1, 16'd1, 6'h01, 10, 11'h3FE);
    tick();
    check_idle("b2b_after");

    send_frame("brr_latch", 8'hA5, 6'h01, 16'd3, 16'd0, 6'h01, 10, 11'h34A);
    tick();
    check_idle("brr_latch_after");

    // Reset during data bit 1 (tx=0, cycles N+9..N+12)
    brr        = 16'd3;
    send_data  = 8'hA5;
    send_start = 1'b1;
    tick();
    send_start = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    check("rst_pre tx", {15'd0, tx}, 16'd0);
    rst = 1'b1;
    tick();
    check_idle("rst_mid");
    rst = 1'b0;
    tick();
    check_idle("rst_release");

    send_frame("brr0", 8'hA5, 6'h01, 16'd0, 16'd0, 6'h01, 10, 11'h34A);
    tick();
    check_idle("brr0_after");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
